// File: rtl/raif_arb_wrr.sv
// RAIF arbiter: CHANNEL_NUM user ports onto one RAIF memory port, with independent
// weighted-round-robin engines for the write path and the read path.

module raif_arb_wrr_engine #(
    parameter int CHANNEL_NUM  = 4,
    parameter int NUM_WIDTH    = 10,
    parameter int WEIGHT_WIDTH = 4,
    parameter int SEL_W        = 2,
    parameter logic [CHANNEL_NUM*WEIGHT_WIDTH-1:0] CH_WEIGHT = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNEL_NUM-1:0]         req_i,
    input  logic [CHANNEL_NUM*NUM_WIDTH-1:0] num_i,
    input  logic                           grant_i,
    input  logic                           finish_i,
    output logic [CHANNEL_NUM-1:0]         grant_o,
    output logic [CHANNEL_NUM-1:0]         finish_o,
    output logic                           req_o,
    output logic                           busy_o,
    output logic [SEL_W-1:0]               sel_o
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_e;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic                    req_q, req_d;
    logic                    zl_q, zl_d;
    logic [SEL_W-1:0]        winner;
    logic                    found;
    logic                    win_zero;
    logic                    done;
    logic [SEL_W-1:0]        done_ch;
    logic [CHANNEL_NUM-1:0]  sel_oh;

    function automatic logic [SEL_W-1:0] ch_add(input logic [SEL_W-1:0] base, input int off);
        int v;
        v = int'(base) + off;
        if (v >= CHANNEL_NUM) v = v - CHANNEL_NUM;
        return SEL_W'(v);
    endfunction

    // A programmed weight of zero still grants one turn.
    function automatic logic [WEIGHT_WIDTH-1:0] weight_of(input logic [SEL_W-1:0] ch);
        logic [WEIGHT_WIDTH-1:0] w;
        w = CH_WEIGHT[int'(ch)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        return (w == '0) ? WEIGHT_WIDTH'(1) : w;
    endfunction

    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (!found && req_i[ch_add(ptr_q, i)]) begin
                winner = ch_add(ptr_q, i);
                found  = 1'b1;
            end
        end
    end

    assign win_zero = (num_i[int'(winner)*NUM_WIDTH +: NUM_WIDTH] == '0);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        req_d    = req_q;
        zl_d     = 1'b0;
        done     = 1'b0;
        done_ch  = sel_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    sel_d = winner;
                    if (win_zero) begin
                        zl_d    = 1'b1;
                        done    = 1'b1;
                        done_ch = winner;
                        state_d = GAP;
                    end else begin
                        req_d   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (finish_i) begin
                    req_d   = 1'b0;
                    done    = 1'b1;
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Credit only lasts while the pointer channel keeps winning.
        if (done) begin
            if (done_ch == ptr_q && credit_q > WEIGHT_WIDTH'(1)) begin
                credit_d = credit_q - WEIGHT_WIDTH'(1);
            end else begin
                ptr_d    = ch_add(done_ch, 1);
                credit_d = weight_of(ch_add(done_ch, 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            ptr_q    <= '0;
            credit_q <= weight_of('0);
            req_q    <= 1'b0;
            zl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            req_q    <= req_d;
            zl_q     <= zl_d;
        end
    end

    assign sel_oh   = CHANNEL_NUM'(1) << sel_q;
    assign busy_o   = (state_q == BUSY);
    assign req_o    = req_q;
    assign sel_o    = sel_q;
    assign grant_o  = (busy_o && grant_i) ? sel_oh : '0;
    assign finish_o = ((busy_o && finish_i) || zl_q) ? sel_oh : '0;

endmodule

module raif_arb_wrr #(
    parameter int APP_DATA_WIDTH = 16,
    parameter int APP_ADDR_WIDTH = 24,
    parameter int NUM_WIDTH      = 10,
    parameter int CHANNEL_NUM    = 4,
    parameter int WEIGHT_WIDTH   = 4,
    parameter logic [CHANNEL_NUM*WEIGHT_WIDTH-1:0] CH_WEIGHT = 16'h1111,
    localparam int SEL_W = (CHANNEL_NUM > 2) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [CHANNEL_NUM-1:0]                wr_req_,
    input  logic [CHANNEL_NUM*APP_ADDR_WIDTH-1:0] wr_addr_,
    input  logic [CHANNEL_NUM*NUM_WIDTH-1:0]      wr_num_,
    input  logic [CHANNEL_NUM*APP_DATA_WIDTH-1:0] wr_data_,
    output logic [CHANNEL_NUM-1:0]                wr_grant_,
    output logic [CHANNEL_NUM-1:0]                wr_finish_,
    input  logic [CHANNEL_NUM-1:0]                rd_req_,
    input  logic [CHANNEL_NUM*APP_ADDR_WIDTH-1:0] rd_addr_,
    input  logic [CHANNEL_NUM*NUM_WIDTH-1:0]      rd_num_,
    output logic [CHANNEL_NUM*APP_DATA_WIDTH-1:0] rd_data_,
    output logic [CHANNEL_NUM-1:0]                rd_grant_,
    output logic [CHANNEL_NUM-1:0]                rd_finish_,
    output logic                                  wr_req,
    output logic [APP_ADDR_WIDTH-1:0]             wr_addr,
    output logic [NUM_WIDTH-1:0]                  wr_num,
    output logic [APP_DATA_WIDTH-1:0]             wr_data,
    input  logic                                  wr_grant,
    input  logic                                  wr_finish,
    output logic                                  rd_req,
    output logic [APP_ADDR_WIDTH-1:0]             rd_addr,
    output logic [NUM_WIDTH-1:0]                  rd_num,
    input  logic [APP_DATA_WIDTH-1:0]             rd_data,
    input  logic                                  rd_grant,
    input  logic                                  rd_finish,
    output logic                                  wr_busy,
    output logic                                  rd_busy,
    output logic [SEL_W-1:0]                      wr_sel,
    output logic [SEL_W-1:0]                      rd_sel
);

    // Handshake: a user holds x_req_ and its slices stable until its x_finish_ pulse;
    // every x_grant_ cycle is one beat; ownership ends only on downstream x_finish.
    raif_arb_wrr_engine #(
        .CHANNEL_NUM(CHANNEL_NUM), .NUM_WIDTH(NUM_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .SEL_W(SEL_W), .CH_WEIGHT(CH_WEIGHT)
    ) u_wr (
        .clk(clk), .rst_n(rst_n), .req_i(wr_req_), .num_i(wr_num_),
        .grant_i(wr_grant), .finish_i(wr_finish), .grant_o(wr_grant_),
        .finish_o(wr_finish_), .req_o(wr_req), .busy_o(wr_busy), .sel_o(wr_sel)
    );

    raif_arb_wrr_engine #(
        .CHANNEL_NUM(CHANNEL_NUM), .NUM_WIDTH(NUM_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .SEL_W(SEL_W), .CH_WEIGHT(CH_WEIGHT)
    ) u_rd (
        .clk(clk), .rst_n(rst_n), .req_i(rd_req_), .num_i(rd_num_),
        .grant_i(rd_grant), .finish_i(rd_finish), .grant_o(rd_grant_),
        .finish_o(rd_finish_), .req_o(rd_req), .busy_o(rd_busy), .sel_o(rd_sel)
    );

    assign wr_addr = wr_busy ? wr_addr_[int'(wr_sel)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH] : '0;
    assign wr_num  = wr_busy ? wr_num_[int'(wr_sel)*NUM_WIDTH +: NUM_WIDTH] : '0;
    assign wr_data = wr_busy ? wr_data_[int'(wr_sel)*APP_DATA_WIDTH +: APP_DATA_WIDTH] : '0;
    assign rd_addr = rd_busy ? rd_addr_[int'(rd_sel)*APP_ADDR_WIDTH +: APP_ADDR_WIDTH] : '0;
    assign rd_num  = rd_busy ? rd_num_[int'(rd_sel)*NUM_WIDTH +: NUM_WIDTH] : '0;

    always_comb begin
        rd_data_ = '0;
        if (rd_busy) rd_data_[int'(rd_sel)*APP_DATA_WIDTH +: APP_DATA_WIDTH] = rd_data;
    end

endmodule

// File: tb/tb_raif_arb_wrr.sv
// Directed bench for raif_arb_wrr (CH=4, weights ch0=3 ch1=1 ch2=0 ch3=0): downstream
// responders, user-port model, and scoreboard monitors fed by expected-owner queues.

module tb_raif_arb_wrr;

    localparam int DW = 16;
    localparam int AW = 24;
    localparam int NW = 10;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [CH-1:0]    wr_req_, wr_grant_, wr_finish_;
    logic [CH*AW-1:0] wr_addr_, rd_addr_;
    logic [CH*NW-1:0] wr_num_, rd_num_;
    logic [CH*DW-1:0] wr_data_, rd_data_;
    logic [CH-1:0]    rd_req_, rd_grant_, rd_finish_;
    logic             wr_req, rd_req, wr_busy, rd_busy;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [NW-1:0]    wr_num, rd_num;
    logic [DW-1:0]    wr_data, rd_data;
    logic             wr_grant = 1'b0, wr_finish = 1'b0;
    logic             rd_grant = 1'b0, rd_finish = 1'b0;
    logic [1:0]       wr_sel, rd_sel;

    logic [AW-1:0] wr_addr_tbl[CH], rd_addr_tbl[CH];
    logic [NW-1:0] wr_num_tbl[CH], rd_num_tbl[CH];
    logic [DW-1:0] wr_data_tbl[CH];
    int            wr_left[CH], rd_left[CH];
    bit            user_en = 1'b0;
    logic [1:0]    wr_exp_q[$];
    logic [1:0]    rd_exp_q[$];
    int            checks = 0;
    int            errors = 0;

    int seq_t1[4] = '{0, 1, 2, 3};
    int seq_t2[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    int seq_t3[6] = '{0, 0, 0, 1, 0, 1};

    raif_arb_wrr #(
        .APP_DATA_WIDTH(DW), .APP_ADDR_WIDTH(AW), .NUM_WIDTH(NW), .CHANNEL_NUM(CH),
        .WEIGHT_WIDTH(4), .CH_WEIGHT(16'h0013)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req_(wr_req_), .wr_addr_(wr_addr_), .wr_num_(wr_num_), .wr_data_(wr_data_),
        .wr_grant_(wr_grant_), .wr_finish_(wr_finish_),
        .rd_req_(rd_req_), .rd_addr_(rd_addr_), .rd_num_(rd_num_), .rd_data_(rd_data_),
        .rd_grant_(rd_grant_), .rd_finish_(rd_finish_),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_num(wr_num), .wr_data(wr_data),
        .wr_grant(wr_grant), .wr_finish(wr_finish),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_num(rd_num), .rd_data(rd_data),
        .rd_grant(rd_grant), .rd_finish(rd_finish),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_sel(wr_sel), .rd_sel(rd_sel)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always_comb begin
        wr_addr_ = '0; wr_num_ = '0; wr_data_ = '0; rd_addr_ = '0; rd_num_ = '0;
        for (int i = 0; i < CH; i++) begin
            wr_addr_[i*AW +: AW] = wr_addr_tbl[i];
            wr_num_[i*NW +: NW]  = wr_num_tbl[i];
            wr_data_[i*DW +: DW] = wr_data_tbl[i];
            rd_addr_[i*AW +: AW] = rd_addr_tbl[i];
            rd_num_[i*NW +: NW]  = rd_num_tbl[i];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: downstream controllers ----------------
    initial begin : wr_responder
        int n;
        forever begin
            @(posedge clk); #1;
            if (rst_n && wr_req) begin
                n = int'(wr_num);
                for (int b = 0; b < n; b++) begin
                    wr_grant = 1'b1;
                    @(posedge clk); #1;
                    if (!rst_n) break;
                end
                wr_grant = 1'b0;
                if (rst_n) begin
                    wr_finish = 1'b1;
                    @(posedge clk); #1;
                    wr_finish = 1'b0;
                end
            end
        end
    end

    initial begin : rd_responder
        int n;
        rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && rd_req) begin
                n = int'(rd_num);
                for (int b = 0; b < n; b++) begin
                    rd_grant = 1'b1;
                    rd_data  = DW'($urandom_range(0, 65535));
                    @(posedge clk); #1;
                    if (!rst_n) break;
                end
                rd_grant = 1'b0;
                if (rst_n) begin
                    rd_finish = 1'b1;
                    @(posedge clk); #1;
                    rd_finish = 1'b0;
                end
            end
        end
    end

    // ---------------- driver: user ports ----------------
    initial begin : users
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (wr_finish_[c] && wr_left[c] > 0) wr_left[c]--;
                if (rd_finish_[c] && rd_left[c] > 0) rd_left[c]--;
            end
            @(posedge clk); #2;
            if (user_en) begin
                for (int c = 0; c < CH; c++) begin
                    wr_req_[c] = (wr_left[c] > 0);
                    rd_req_[c] = (rd_left[c] > 0);
                end
            end
        end
    end

    // ---------------- scoreboard monitors ----------------
    initial begin : wr_mon
        logic       prev;
        int         g;
        logic [1:0] f;
        logic [3:0] oh;
        prev = 1'b0; g = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0; g = 0;
            end else begin
                if (wr_req && !prev) begin
                    if (wr_exp_q.size() == 0) chk("wr_spurious_req", 1, 0);
                    else begin
                        f = wr_exp_q[0];
                        chk("wr_sel", wr_sel, f);
                        chk("wr_addr", wr_addr, wr_addr_tbl[f]);
                        chk("wr_num", wr_num, wr_num_tbl[f]);
                    end
                    g = 0;
                end
                if (wr_grant_ != '0) begin
                    if (wr_exp_q.size() == 0) chk("wr_spurious_grant", wr_grant_, 0);
                    else begin
                        f = wr_exp_q[0]; oh = 4'b0001 << f;
                        chk("wr_grant_owner", wr_grant_, oh);
                        chk("wr_data", wr_data, wr_data_tbl[f]);
                    end
                    g++;
                end
                if (wr_finish_ != '0) begin
                    if (wr_exp_q.size() == 0) chk("wr_spurious_finish", wr_finish_, 0);
                    else begin
                        f = wr_exp_q.pop_front(); oh = 4'b0001 << f;
                        chk("wr_finish_owner", wr_finish_, oh);
                        chk("wr_beats", g, wr_num_tbl[f]);
                    end
                    g = 0;
                end
                prev = wr_req;
            end
        end
    end

    initial begin : rd_mon
        logic          prev;
        int            g;
        logic [1:0]    f;
        logic [3:0]    oh;
        logic [CH*DW-1:0] ev;
        prev = 1'b0; g = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0; g = 0;
            end else begin
                if (rd_req && !prev) begin
                    if (rd_exp_q.size() == 0) chk("rd_spurious_req", 1, 0);
                    else begin
                        f = rd_exp_q[0];
                        chk("rd_sel", rd_sel, f);
                        chk("rd_addr", rd_addr, rd_addr_tbl[f]);
                        chk("rd_num", rd_num, rd_num_tbl[f]);
                    end
                    g = 0;
                end
                if (rd_grant_ != '0) begin
                    if (rd_exp_q.size() == 0) chk("rd_spurious_grant", rd_grant_, 0);
                    else begin
                        f = rd_exp_q[0]; oh = 4'b0001 << f;
                        ev = '0; ev[f*DW +: DW] = rd_data;
                        chk("rd_grant_owner", rd_grant_, oh);
                        chk("rd_data_slice", rd_data_, ev);
                    end
                    g++;
                end
                if (rd_finish_ != '0) begin
                    if (rd_exp_q.size() == 0) chk("rd_spurious_finish", rd_finish_, 0);
                    else begin
                        f = rd_exp_q.pop_front(); oh = 4'b0001 << f;
                        chk("rd_finish_owner", rd_finish_, oh);
                        chk("rd_beats", g, rd_num_tbl[f]);
                    end
                    g = 0;
                end
                prev = rd_req;
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((wr_exp_q.size() != 0 || rd_exp_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_drained"}, (n < 2000), 1);
        if (n >= 2000) begin
            wr_exp_q.delete(); rd_exp_q.delete();
            for (int c = 0; c < CH; c++) begin wr_left[c] = 0; rd_left[c] = 0; end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    initial begin : main
        int  g;
        bit  zl_req_seen;
        for (int c = 0; c < CH; c++) begin
            wr_addr_tbl[c] = AW'(24'h100000 * (c + 1) + c);
            wr_num_tbl[c]  = NW'(8);
            wr_data_tbl[c] = DW'(16'hA0A0 ^ (c * 16'h0111));
            rd_addr_tbl[c] = AW'(24'h800000 | (c << 4));
            rd_num_tbl[c]  = NW'(c + 2);
            wr_left[c] = 0; rd_left[c] = 0;
        end
        wr_req_ = '1; rd_req_ = '1;

        // reset with every request asserted
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_req", wr_req, 0);       chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_busy", wr_busy, 0);     chk("rst_rd_busy", rd_busy, 0);
        chk("rst_wr_sel", wr_sel, 0);       chk("rst_rd_sel", rd_sel, 0);
        chk("rst_wr_grant_", wr_grant_, 0); chk("rst_rd_grant_", rd_grant_, 0);
        chk("rst_wr_finish_", wr_finish_, 0); chk("rst_rd_finish_", rd_finish_, 0);
        chk("rst_wr_addr", wr_addr, 0);     chk("rst_wr_num", wr_num, 0);
        chk("rst_wr_data", wr_data, 0);     chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_num", rd_num, 0);       chk("rst_rd_data_", rd_data_, 0);

        // release: one write per channel, rotation from ch0
        for (int i = 0; i < 4; i++) begin
            wr_left[i] = 1;
            wr_exp_q.push_back(2'(seq_t1[i]));
        end
        user_en = 1'b1;
        rst_n   = 1'b1;
        @(negedge clk);
        chk("rel_wr_req_before_edge", wr_req, 0);
        @(negedge clk);
        chk("rel_wr_req_after_edge", wr_req, 1);
        chk("rel_wr_sel", wr_sel, 0);
        drain("t1");

        // all write channels requesting (ch0 weight 3); all read channels once
        wr_left[0] = 6; wr_left[1] = 1; wr_left[2] = 1; wr_left[3] = 1;
        for (int i = 0; i < 9; i++) wr_exp_q.push_back(2'(seq_t2[i]));
        for (int i = 0; i < 4; i++) begin
            rd_left[i] = 1;
            rd_exp_q.push_back(2'(seq_t1[i]));
        end
        drain("t2");

        // zero-length request on ch2, then a normal request on ch1
        wr_num_tbl[2] = '0;
        wr_left[2] = 1;
        wr_exp_q.push_back(2'd2);
        zl_req_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req) zl_req_seen = 1'b1;
            if (wr_finish_[2]) break;
        end
        chk("zl_finish_seen", wr_finish_, 4'b0100);
        chk("zl_no_downstream_req", zl_req_seen, 0);
        @(negedge clk);
        chk("zl_pulse_one_cycle", wr_finish_, 0);
        drain("t4a");
        wr_num_tbl[2] = NW'(8);
        wr_left[1] = 1;
        wr_exp_q.push_back(2'd1);
        drain("t4b");

        // concurrent write ch1 and read ch3
        wr_left[1] = 1; rd_left[3] = 1;
        wr_exp_q.push_back(2'd1); rd_exp_q.push_back(2'd3);
        @(posedge clk);
        @(negedge clk);
        chk("conc_wr_sel", wr_sel, 1);   chk("conc_rd_sel", rd_sel, 3);
        chk("conc_wr_busy", wr_busy, 1); chk("conc_rd_busy", rd_busy, 1);
        drain("t5");

        // async reset after 3 of 8 grants
        wr_left[0] = 1;
        wr_exp_q.push_back(2'd0);
        g = 0;
        for (int i = 0; i < 40 && g < 3; i++) begin
            @(negedge clk);
            if (wr_grant_[0]) g++;
        end
        chk("mid_grants_before_reset", g, 3);
        rst_n = 1'b0;
        #1;
        chk("arst_wr_busy", wr_busy, 0);
        chk("arst_wr_req", wr_req, 0);
        chk("arst_wr_grant_", wr_grant_, 0);
        chk("arst_wr_finish_", wr_finish_, 0);
        wr_exp_q.delete(); rd_exp_q.delete();
        for (int c = 0; c < CH; c++) begin wr_left[c] = 0; rd_left[c] = 0; end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // from reset state, ch0 and ch1 always requesting
        wr_left[0] = 4; wr_left[1] = 2;
        for (int i = 0; i < 6; i++) wr_exp_q.push_back(2'(seq_t3[i]));
        drain("t3");

        // downstream grant/finish while idle must not reach any user port
        wr_grant = 1'b1; wr_finish = 1'b1; rd_grant = 1'b1; rd_finish = 1'b1;
        @(negedge clk);
        chk("idle_wr_grant_", wr_grant_, 0);   chk("idle_wr_finish_", wr_finish_, 0);
        chk("idle_rd_grant_", rd_grant_, 0);   chk("idle_rd_finish_", rd_finish_, 0);
        @(posedge clk);
        #1;
        wr_grant = 1'b0; wr_finish = 1'b0; rd_grant = 1'b0; rd_finish = 1'b0;
        @(negedge clk);
        chk("idle_wr_busy", wr_busy, 0);
        chk("idle_rd_busy", rd_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
